// File: rtl/seg7_scan_decoder_if.sv
// Display-bus bundle: multiplexed segment/select lines from the display driver
// and the recovered-value readback reported by the scan decoder.
interface seg7_scan_decoder_if #(
  parameter int unsigned NUM_DIGITS = 4
);

  // Active-low segment lines, a..g
  logic a;
  logic b;
  logic c;
  logic d;
  logic e;
  logic f;
  logic g;

  // Active-low digit selects, one-hot while driving
  logic [NUM_DIGITS-1:0]   an;

  // Readback side
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    update;
  logic [2:0]              update_idx;
  logic                    error;

  // Display driver / stimulus side
  modport master (
    output a, b, c, d, e, f, g, an,
    input  digits, digit_valid, update, update_idx, error
  );

  // Scan decoder side
  modport slave (
    input  a, b, c, d, e, f, g, an,
    output digits, digit_valid, update, update_idx, error
  );

endinterface

// File: rtl/seg7_scan_decoder.sv
// Seven-segment scan readback monitor: synchronises the multiplexed display
// bus, waits for a stable pattern and recovers the BCD value shown on each
// digit, flagging illegal segment patterns or multi-digit selects.
module seg7_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_scan_decoder_if.slave   bus
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned VEC_W = SEG_W + NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned DIG_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_EVAL = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;

  // Maps an active-low {a..g} vector to {legal, bcd}; illegal returns 0_1111.
  function automatic logic [4:0] decode_seg(input logic [SEG_W-1:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = 5'b1_0000;
      7'b1001111: r = 5'b1_0001;
      7'b0010010: r = 5'b1_0010;
      7'b0000110: r = 5'b1_0011;
      7'b1001100: r = 5'b1_0100;
      7'b0100100: r = 5'b1_0101;
      7'b0100000: r = 5'b1_0110;
      7'b0001111: r = 5'b1_0111;
      7'b0000000: r = 5'b1_1000;
      7'b0000100: r = 5'b1_1001;
      default:    r = 5'b0_1111;
    endcase
    return r;
  endfunction

  // Input path
  logic [VEC_W-1:0]      raw_c;
  logic [VEC_W-1:0]      sync1_q;
  logic [VEC_W-1:0]      sync2_q;
  logic [VEC_W-1:0]      prev_q;

  // Stability window
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  changed_c;
  logic                  eval_c;

  // Decoded view of the synchronised pattern
  logic [SEG_W-1:0]      seg_c;
  logic [NUM_DIGITS-1:0] sel_c;
  logic                  none_c;
  logic                  multi_c;
  logic [2:0]            idx_c;
  logic [3:0]            cur_val_c;
  logic                  cur_vld_c;
  logic [4:0]            dec_c;

  // Digit write request
  logic                  wr_c;
  logic [3:0]            new_val_c;
  logic                  new_vld_c;

  // Registered outputs
  logic [DIG_W-1:0]      digits_q;
  logic [DIG_W-1:0]      digits_d;
  logic [NUM_DIGITS-1:0] valid_q;
  logic [NUM_DIGITS-1:0] valid_d;
  logic                  update_q;
  logic                  update_d;
  logic [2:0]            update_idx_q;
  logic [2:0]            update_idx_d;
  logic                  error_q;
  logic                  error_d;

  assign raw_c = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.an};

  // Two-flop synchroniser plus one-cycle history; all ones reads as blank/idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= raw_c;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Saturating stability counter; evaluation fires once per stable window
  always_comb begin
    changed_c = (sync2_q != prev_q);
    cnt_d     = cnt_q;
    if (changed_c) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    eval_c = !changed_c && (cnt_q == CNT_EVAL);
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Select decode: none / several / exactly one digit, plus that digit's state
  always_comb begin
    seg_c     = sync2_q[VEC_W-1 -: SEG_W];
    sel_c     = ~sync2_q[NUM_DIGITS-1:0];
    none_c    = (sel_c == '0);
    multi_c   = ((sel_c & (sel_c - NUM_DIGITS'(1))) != '0);
    dec_c     = decode_seg(seg_c);
    idx_c     = '0;
    cur_val_c = 4'hF;
    cur_vld_c = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (sel_c[i]) begin
        idx_c     = 3'(i);
        cur_val_c = digits_q[4*i +: 4];
        cur_vld_c = valid_q[i];
      end
    end
  end

  // Evaluation: decide on write, update strobe or error strobe
  always_comb begin
    digits_d     = digits_q;
    valid_d      = valid_q;
    update_d     = 1'b0;
    update_idx_d = update_idx_q;
    error_d      = 1'b0;
    wr_c         = 1'b0;
    new_val_c    = 4'hF;
    new_vld_c    = 1'b0;

    if (eval_c && !none_c) begin
      if (multi_c) begin
        error_d = 1'b1;
      end else if (dec_c[4]) begin
        if (!cur_vld_c || (cur_val_c != dec_c[3:0])) begin
          wr_c         = 1'b1;
          new_val_c    = dec_c[3:0];
          new_vld_c    = 1'b1;
          update_d     = 1'b1;
          update_idx_d = idx_c;
        end
      end else if (seg_c == SEG_OFF) begin
        if (cur_vld_c) begin
          wr_c         = 1'b1;
          new_val_c    = 4'hF;
          new_vld_c    = 1'b0;
          update_d     = 1'b1;
          update_idx_d = idx_c;
        end
      end else begin
        error_d = 1'b1;
      end
    end

    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (wr_c && sel_c[i]) begin
        digits_d[4*i +: 4] = new_val_c;
        valid_d[i]         = new_vld_c;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q     <= '1;
      valid_q      <= '0;
      update_q     <= 1'b0;
      update_idx_q <= '0;
      error_q      <= 1'b0;
    end else begin
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      update_q     <= update_d;
      update_idx_q <= update_idx_d;
      error_q      <= error_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.update      = update_q;
  assign bus.update_idx  = update_idx_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: table of held display patterns with expected
// readback events, a scoreboard queue matched against update/error pulses,
// and hand-written reset/latency sequences.
module tb_seg7_scan_decoder;

  logic clk;
  logic rst_n;

  seg7_scan_decoder_if #(.NUM_DIGITS(4)) bus_if ();

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 none, 1 update, 2 error (matches {error, update})
  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  idx;
    logic [15:0] dig;
    logic [3:0]  vld;
  } ev_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         hold;
    ev_t        ev;
  } vec_t;

  vec_t vecs[$];
  ev_t  sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic add(input logic [3:0] an, input logic [6:0] seg, input int hold,
                     input logic [1:0] kind, input logic [2:0] idx,
                     input logic [15:0] dig, input logic [3:0] vld);
    vec_t v;
    v.an      = an;
    v.seg     = seg;
    v.hold    = hold;
    v.ev.kind = kind;
    v.ev.idx  = idx;
    v.ev.dig  = dig;
    v.ev.vld  = vld;
    vecs.push_back(v);
  endtask

  // Called at posedge+2; holds the pattern for n rising edges, returns at posedge+2
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    bus_if.an = an;
    {bus_if.a, bus_if.b, bus_if.c, bus_if.d, bus_if.e, bus_if.f, bus_if.g} = seg;
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expected event
  always @(negedge clk) begin : sb_mon
    ev_t act;
    ev_t exp;
    if (rst_n && (bus_if.update || bus_if.error)) begin
      act.kind = {bus_if.error, bus_if.update};
      act.idx  = bus_if.error ? 3'd0 : bus_if.update_idx;
      act.dig  = bus_if.digits;
      act.vld  = bus_if.digit_valid;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pulse", 32'(act), 32'(0));
      end else begin
        exp = sb_q.pop_front();
        check("sb_event", 32'(act), 32'(exp));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int first;

    // Stimulus table: pattern, hold cycles, expected event (kind idx digits valid)
    add(4'b1110, 7'b0010010, 30, 2'd1, 3'd0, 16'hFFF2, 4'b0001); // 2 on digit0, held long
    add(4'b1110, 7'b1001111,  8, 2'd1, 3'd0, 16'hFFF1, 4'b0001); // scan pass 1
    add(4'b1101, 7'b0010010,  8, 2'd1, 3'd1, 16'hFF21, 4'b0011);
    add(4'b1011, 7'b0000110,  8, 2'd1, 3'd2, 16'hF321, 4'b0111);
    add(4'b0111, 7'b1001100,  8, 2'd1, 3'd3, 16'h4321, 4'b1111);
    add(4'b1110, 7'b1001111,  8, 2'd0, 3'd0, 16'h0000, 4'b0000); // scan pass 2: no events
    add(4'b1101, 7'b0010010,  8, 2'd0, 3'd0, 16'h0000, 4'b0000);
    add(4'b1011, 7'b0000110,  8, 2'd0, 3'd0, 16'h0000, 4'b0000);
    add(4'b0111, 7'b1001100,  8, 2'd0, 3'd0, 16'h0000, 4'b0000);
    for (int k = 0; k < 10; k++) begin                          // glitching segments
      add(4'b1101, (k % 2 == 0) ? 7'b0000000 : 7'b0000001, 2, 2'd0, 3'd0, 16'h0000, 4'b0000);
    end
    add(4'b1101, 7'b0001111,  8, 2'd1, 3'd1, 16'h4371, 4'b1111); // 7 on digit1
    add(4'b1110, 7'b1111110,  8, 2'd2, 3'd0, 16'h4371, 4'b1111); // illegal pattern
    add(4'b0101, 7'b0010010,  8, 2'd2, 3'd0, 16'h4371, 4'b1111); // two selects
    add(4'b1111, 7'b0000000,  8, 2'd0, 3'd0, 16'h0000, 4'b0000); // nothing selected
    add(4'b1011, 7'b0000100,  8, 2'd1, 3'd2, 16'h4971, 4'b1111); // 9 on digit2
    add(4'b1011, 7'b1111111,  8, 2'd1, 3'd2, 16'h4F71, 4'b1011); // blank digit2
    add(4'b1111, 7'b1111111,  8, 2'd0, 3'd0, 16'h0000, 4'b0000);
    add(4'b1011, 7'b1111111,  8, 2'd0, 3'd0, 16'h0000, 4'b0000); // blank already-invalid
    add(4'b1110, 7'b0000001,  8, 2'd1, 3'd0, 16'h4F70, 4'b1011); // 0
    add(4'b1110, 7'b0000000,  8, 2'd1, 3'd0, 16'h4F78, 4'b1011); // 8
    add(4'b0111, 7'b0100000,  8, 2'd1, 3'd3, 16'h6F78, 4'b1011); // 6

    // Reset state
    rst_n     = 1'b0;
    bus_if.an = 4'b1111;
    {bus_if.a, bus_if.b, bus_if.c, bus_if.d, bus_if.e, bus_if.f, bus_if.g} = 7'b1111111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits",     32'(bus_if.digits),      32'hFFFF);
    check("rst_valid",      32'(bus_if.digit_valid), 32'h0);
    check("rst_update",     32'(bus_if.update),      32'h0);
    check("rst_update_idx", 32'(bus_if.update_idx),  32'h0);
    check("rst_error",      32'(bus_if.error),       32'h0);
    #1 rst_n = 1'b1;

    // Table-driven run
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].ev.kind != 2'd0) sb_q.push_back(vecs[i].ev);
      drive(vecs[i].an, vecs[i].seg, vecs[i].hold);
    end
    repeat (10) @(posedge clk);
    #1;
    check("tbl_sb_drained",  32'(sb_q.size()),        32'd0);
    check("tbl_digits",      32'(bus_if.digits),      32'h6F78);
    check("tbl_valid",       32'(bus_if.digit_valid), 32'hB);
    #1;

    // Async reset in the middle of a stability window
    drive(4'b1110, 7'b0100100, 3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_digits",     32'(bus_if.digits),      32'hFFFF);
    check("mid_rst_valid",      32'(bus_if.digit_valid), 32'h0);
    check("mid_rst_update_idx", 32'(bus_if.update_idx),  32'h0);
    check("mid_rst_update",     32'(bus_if.update),      32'h0);
    check("mid_rst_error",      32'(bus_if.error),       32'h0);

    // Release with pattern already held: first strobe after edge STABLE_CYCLES+2
    sb_q.push_back('{kind: 2'd1, idx: 3'd0, dig: 16'hFFF5, vld: 4'b0001});
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    first = -1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (first < 0 && (bus_if.update || bus_if.error)) first = e;
    end
    check("rel_latency_edge", 32'(first), 32'd6);
    repeat (20) @(posedge clk);
    #1;
    check("rel_sb_drained", 32'(sb_q.size()),   32'd0);
    check("rel_digits",     32'(bus_if.digits), 32'hFFF5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
